// File: rtl/sincos_sched.sv
// Round-robin scheduler sharing one fixed-latency sin/cos pipeline among N_REQ requesters.
// Define SINCOS_SCHED_STATS_EN to add the stat_issued / stat_stall counter outputs.
module sincos_sched #(
  parameter int N_REQ   = 4,
  parameter int ANGLE_W = 27,
  parameter int DATA_W  = 27,
  parameter int LATENCY = 8,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ANGLE_W-1:0]   req_angle,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic [DATA_W-1:0]          resp_sin,
  output logic [DATA_W-1:0]          resp_cos,
  input  logic                       resp_ready,
  output logic                       sc_en,
  output logic [ANGLE_W-1:0]         sc_angle,
  input  logic [DATA_W-1:0]          sc_sin,
  input  logic [DATA_W-1:0]          sc_cos,
  output logic                       busy
`ifdef SINCOS_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall
`endif
);

  localparam int unsigned N_U = N_REQ;

  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]    tag_id_q [LATENCY];
  logic [ID_W-1:0]    tag_id_d [LATENCY];
  logic [ID_W-1:0]    last_grant_q, last_grant_d;

  logic               advance;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  int unsigned        idx;

  // Output stage is masked during reset so stale tags never surface.
  assign resp_valid = tag_valid_q[LATENCY-1] && !rst;
  assign resp_id    = tag_id_q[LATENCY-1];
  assign resp_sin   = sc_sin;
  assign resp_cos   = sc_cos;
  assign advance    = !resp_valid || resp_ready;
  assign sc_en      = advance;
  assign busy       = (|tag_valid_q) && !rst;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= N_U; i++) begin
      idx = (32'(last_grant_q) + i) % N_U;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (!advance || rst) begin
      grant_any = 1'b0;
      grant_id  = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    sc_angle  = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      if (grant_any && grant_id == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        sc_angle     = req_angle[i*ANGLE_W +: ANGLE_W];
      end
    end
  end

  always_comb begin
    tag_valid_d  = tag_valid_q;
    tag_id_d     = tag_id_q;
    last_grant_d = last_grant_q;
    if (advance) begin
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_id_d[i]    = tag_id_q[i-1];
      end
      tag_valid_d[0] = grant_any;
      tag_id_d[0]    = grant_any ? grant_id : '0;
    end
    if (grant_any) begin
      last_grant_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q  <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
      last_grant_q <= ID_W'(N_REQ - 1);
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef SINCOS_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q + {31'd0, grant_any};
    stat_stall_d  = stat_stall_q + {31'd0, ~advance};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_sincos_sched.sv
// Self-checking bench for sincos_sched: queue-based reference model plus a fake sin/cos pipeline.
module tb_sincos_sched;
  localparam int N  = 4;
  localparam int AW = 27;
  localparam int DW = 27;
  localparam int L  = 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_angle;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [DW-1:0]     resp_sin;
  logic [DW-1:0]     resp_cos;
  logic              resp_ready;
  logic              sc_en;
  logic [AW-1:0]     sc_angle;
  logic [DW-1:0]     sc_sin;
  logic [DW-1:0]     sc_cos;
  logic              busy;
`ifdef SINCOS_SCHED_STATS_EN
  logic [31:0]       stat_issued;
  logic [31:0]       stat_stall;
`endif

  sincos_sched #(.N_REQ(N), .ANGLE_W(AW), .DATA_W(DW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sin(resp_sin), .resp_cos(resp_cos), .resp_ready(resp_ready),
    .sc_en(sc_en), .sc_angle(sc_angle), .sc_sin(sc_sin), .sc_cos(sc_cos),
    .busy(busy)
`ifdef SINCOS_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f_sin(input logic [AW-1:0] a);
    return a ^ 27'h5A5A5A5;
  endfunction
  function automatic logic [DW-1:0] f_cos(input logic [AW-1:0] a);
    return {a[0], a[AW-1:1]} + 27'd3;
  endfunction

  // Stand-in sin/cos unit: L-deep pipe advancing only on sc_en.
  logic [AW-1:0] sc_pipe [L];
  always @(posedge clk) begin
    if (sc_en === 1'b1) begin
      for (int i = L - 1; i > 0; i--) sc_pipe[i] <= sc_pipe[i-1];
      sc_pipe[0] <= sc_angle;
    end
  end
  assign sc_sin = f_sin(sc_pipe[L-1]);
  assign sc_cos = f_cos(sc_pipe[L-1]);

  typedef struct {
    int            id;
    logic [AW-1:0] ang;
    int            age;
  } item_t;

  item_t         mq[$];
  int            m_last;
  int            m_issued;
  int            m_stall;
  bit            m_known;
  logic [AW-1:0] ang [N];

  int            n_cmp;
  int            n_err;

  logic [N-1:0]  obs_ready;
  logic          obs_rv;
  logic          obs_busy;
  logic          obs_sc_en;
  logic [1:0]    obs_id;
  logic [DW-1:0] obs_sin;
  logic [31:0]   obs_issued;
  logic [31:0]   obs_stall;

  // One clock: drive inputs, check every output against the model, then advance the model.
  task automatic drive_cycle(input logic r, input logic [N-1:0] rv, input logic rdy);
    logic          exp_rv;
    logic          exp_adv;
    int            exp_g;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] exp_ang;
    rst        = r;
    req_valid  = rv;
    resp_ready = rdy;
    for (int k = 0; k < N; k++) req_angle[k*AW +: AW] = ang[k];
    #1;
    exp_rv  = !r && mq.size() > 0 && mq[0].age == L;
    exp_adv = !exp_rv || rdy;
    exp_g   = -1;
    if (!r && exp_adv) begin
      for (int i = 1; i <= N; i++) begin
        if (exp_g < 0 && rv[(m_last + i) % N]) exp_g = (m_last + i) % N;
      end
    end
    exp_ready = '0;
    exp_ang   = '0;
    if (exp_g >= 0) begin
      exp_ready[exp_g] = 1'b1;
      exp_ang = ang[exp_g];
    end
    n_cmp++;
    if (resp_valid !== exp_rv) begin
      n_err++; $display("FAIL resp_valid: got %b want %b at %0t", resp_valid, exp_rv, $time);
    end
    n_cmp++;
    if (req_ready !== exp_ready) begin
      n_err++; $display("FAIL req_ready: got %b want %b at %0t", req_ready, exp_ready, $time);
    end
    n_cmp++;
    if (sc_en !== exp_adv) begin
      n_err++; $display("FAIL sc_en: got %b want %b at %0t", sc_en, exp_adv, $time);
    end
    n_cmp++;
    if (sc_angle !== exp_ang) begin
      n_err++; $display("FAIL sc_angle: got %h want %h at %0t", sc_angle, exp_ang, $time);
    end
    n_cmp++;
    if (busy !== (!r && mq.size() > 0)) begin
      n_err++; $display("FAIL busy: got %b want %b at %0t", busy, (!r && mq.size() > 0), $time);
    end
    if (exp_rv) begin
      n_cmp++;
      if (resp_id !== 2'(mq[0].id) || resp_sin !== f_sin(mq[0].ang) || resp_cos !== f_cos(mq[0].ang)) begin
        n_err++;
        $display("FAIL resp_data: got id=%0d sin=%h cos=%h want id=%0d sin=%h cos=%h at %0t",
                 resp_id, resp_sin, resp_cos, mq[0].id, f_sin(mq[0].ang), f_cos(mq[0].ang), $time);
      end
    end
`ifdef SINCOS_SCHED_STATS_EN
    if (!r && m_known) begin
      n_cmp++;
      if (stat_issued !== 32'(m_issued) || stat_stall !== 32'(m_stall)) begin
        n_err++;
        $display("FAIL stats: got issued=%0d stall=%0d want issued=%0d stall=%0d at %0t",
                 stat_issued, stat_stall, m_issued, m_stall, $time);
      end
    end
    obs_issued = stat_issued;
    obs_stall  = stat_stall;
`else
    obs_issued = '0;
    obs_stall  = '0;
`endif
    obs_ready = req_ready;
    obs_rv    = resp_valid;
    obs_busy  = busy;
    obs_sc_en = sc_en;
    obs_id    = resp_id;
    obs_sin   = resp_sin;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_last   = N - 1;
      m_issued = 0;
      m_stall  = 0;
      m_known  = 1'b1;
    end else if (!exp_adv) begin
      m_stall++;
    end else begin
      if (exp_rv) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (exp_g >= 0) begin
        mq.push_back('{id: exp_g, ang: ang[exp_g], age: 1});
        m_last = exp_g;
        m_issued++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) ang[k] = AW'($urandom);
    drive_cycle(1'b1, 4'b1111, 1'b1);
    drive_cycle(1'b1, 4'b1111, 1'b0);
    n_cmp++;
    if (obs_ready !== 4'b0000 || obs_rv !== 1'b0 || obs_busy !== 1'b0 || obs_sc_en !== 1'b1) begin
      n_err++; $display("FAIL reset_outputs: got ready=%b rv=%b busy=%b sc_en=%b want 0000/0/0/1",
                        obs_ready, obs_rv, obs_busy, obs_sc_en);
    end
  endtask

  task automatic test_single_issue();
    drive_cycle(1'b1, 4'b0000, 1'b1);
    ang[0] = 27'h0400000;
    drive_cycle(1'b0, 4'b0001, 1'b1);
    n_cmp++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_grant: got %b want 0001", obs_ready);
    end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1);
      n_cmp++;
      if (obs_rv !== (k == 8)) begin
        n_err++; $display("FAIL single_latency: cycle %0d got rv=%b want %b", k, obs_rv, (k == 8));
      end
      if (k < 8) begin
        n_cmp++;
        if (obs_busy !== 1'b1) begin
          n_err++; $display("FAIL single_busy: cycle %0d got %b want 1", k, obs_busy);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if (obs_id !== 2'd0 || obs_sin !== f_sin(27'h0400000)) begin
          n_err++; $display("FAIL single_resp: got id=%0d sin=%h want id=0 sin=%h",
                            obs_id, obs_sin, f_sin(27'h0400000));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    drive_cycle(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) if (i % N == 0) ang[k] = AW'($urandom);
      drive_cycle(1'b0, 4'b1111, 1'b1);
      n_cmp++;
      if (obs_ready !== 4'(1 << (i % N))) begin
        n_err++; $display("FAIL rr_grant: step %0d got %b want %b", i, obs_ready, 4'(1 << (i % N)));
      end
      if (obs_rv) ids.push_back(int'(obs_id));
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1);
      if (obs_rv) ids.push_back(int'(obs_id));
    end
    n_cmp++;
    if (ids.size() != 8) begin
      n_err++; $display("FAIL rr_resp_count: got %0d want 8", ids.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (ids[i] != i % N) begin
          n_err++; $display("FAIL rr_resp_order: slot %0d got %0d want %0d", i, ids[i], i % N);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    int responded;
    bit seen;
    logic [1:0]    hold_id;
    logic [DW-1:0] hold_sin;
    logic [31:0]   stall0;
    accepted  = 0;
    responded = 0;
    seen      = 1'b0;
    ang[2]    = AW'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_cycle(1'b0, 4'b0100, 1'b1);
      if (obs_ready[2]) begin accepted++; ang[2] = AW'($urandom); end
      if (obs_rv) begin responded++; seen = 1'b1; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL bp_first_resp: got none want resp within 20 cycles");
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 4'b0100, 1'b0);
      if (i == 0) begin hold_id = obs_id; hold_sin = obs_sin; stall0 = obs_stall; end
      n_cmp++;
      if (obs_rv !== 1'b1 || obs_sc_en !== 1'b0 || obs_ready !== 4'b0000 ||
          obs_id !== hold_id || obs_sin !== hold_sin) begin
        n_err++; $display("FAIL bp_stall: cycle %0d got rv=%b sc_en=%b ready=%b id=%0d sin=%h want 1/0/0000/%0d/%h",
                          i, obs_rv, obs_sc_en, obs_ready, obs_id, obs_sin, hold_id, hold_sin);
      end
    end
    drive_cycle(1'b0, 4'b0100, 1'b1);
    if (obs_ready[2]) accepted++;
    if (obs_rv) responded++;
`ifdef SINCOS_SCHED_STATS_EN
    n_cmp++;
    if (obs_stall - stall0 !== 32'd3) begin
      n_err++; $display("FAIL bp_stat_stall: got %0d want 3", obs_stall - stall0);
    end
`endif
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1);
      if (obs_rv) responded++;
    end
    n_cmp++;
    if (responded != accepted) begin
      n_err++; $display("FAIL bp_conservation: got %0d responses want %0d", responded, accepted);
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < N; k++) ang[k] = AW'($urandom);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'b1111, 1'b1);
    drive_cycle(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 4'b0000, 1'b1);
      n_cmp++;
      if (obs_rv !== 1'b0 || obs_busy !== 1'b0) begin
        n_err++; $display("FAIL midflight_quiet: cycle %0d got rv=%b busy=%b want 0/0", i, obs_rv, obs_busy);
      end
    end
    drive_cycle(1'b0, 4'b1111, 1'b1);
    n_cmp++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL midflight_regrant: got %b want 0001", obs_ready);
    end
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_sparse();
    int i0;
    logic [31:0] iss0;
    i0 = m_issued;
    for (int i = 0; i < 8; i++) begin
      ang[1] = AW'($urandom);
      ang[3] = AW'($urandom);
      drive_cycle(1'b0, 4'b1010, 1'b1);
      if (i == 0) iss0 = obs_issued;
      n_cmp++;
      if (obs_ready !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_err++; $display("FAIL sparse_grant: step %0d got %b want %b",
                          i, obs_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      end
    end
    drive_cycle(1'b0, 4'b0000, 1'b1);
`ifdef SINCOS_SCHED_STATS_EN
    n_cmp++;
    if (obs_issued - iss0 !== 32'd8) begin
      n_err++; $display("FAIL sparse_stat_issued: got %0d want 8", obs_issued - iss0);
    end
`endif
    n_cmp++;
    if (m_issued - i0 != 8) begin
      n_err++; $display("FAIL sparse_accept_count: got %0d want 8", m_issued - i0);
    end
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          pend[k] = 1'b1;
          ang[k]  = AW'($urandom);
        end
      end
      drive_cycle(1'b0, pend, $urandom_range(3, 0) != 0);
      pend = pend & ~obs_ready;
    end
    for (int i = 0; i < 15; i++) drive_cycle(1'b0, 4'b0000, 1'b1);
    n_cmp++;
    if (mq.size() != 0) begin
      n_err++; $display("FAIL random_drain: got %0d outstanding want 0", mq.size());
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    m_known    = 1'b0;
    m_last     = N - 1;
    m_issued   = 0;
    m_stall    = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_angle  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_issue();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_sparse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
